pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hBFC00000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clk_enable  input  1  global stall; when low, all state holds.
REQ-005 SHALL have port pc_sel  input  2  decoder redirect select: 00 sequential, 01 branch, 10 jump, 11 register.
REQ-006 SHALL have port instr_readdata  input  32  current instruction word; bits [15:0] are the branch offset and bits [25:0] the jump index.
REQ-007 SHALL have port reg_readdata  input  32  rs value, used as the JR/JALR target.
REQ-008 SHALL have port instr_address  output  32  address of the instruction currently executing (fetch address).
REQ-009 SHALL have port link_addr  output  32  instr_address+8, the return address for JAL/JALR/BxxAL.
REQ-010 SHALL have port active  output  1  high while the CPU is running; low after halt.

Function
REQ-011 SHALL implement states RUN, DELAY and HALTED, held in a registered state variable.
REQ-012 SHALL, in RUN with clk_enable=1 and pc_sel=00, advance pc to pc+4 (mod 2^32) with no pending target.
REQ-013 SHALL, in RUN with clk_enable=1 and pc_sel!=00, capture the target into pending_target, advance pc to pc+4 (the delay-slot instruction) and enter DELAY.
REQ-014 SHALL compute the branch target as (pc+4) + (sign-extended instr_readdata[15:0] << 2), with 32-bit wrap-around.
REQ-015 SHALL compute the jump target as {(pc+4)[31:28], instr_readdata[25:0], 2'b00}.
REQ-016 SHALL take the register target from reg_readdata unmodified; the low 2 bits are not masked.
REQ-017 SHALL, in DELAY with clk_enable=1, load pc with pending_target and return to RUN, ignoring pc_sel (a redirect in a delay slot is discarded).
REQ-018 SHALL, when leaving DELAY with pending_target==32'h0, load pc=0, enter HALTED and drive active=0 from the next cycle.
REQ-019 SHALL, in HALTED, hold pc and active=0 regardless of pc_sel or clk_enable until reset.
REQ-020 SHALL, with clk_enable=0, hold pc, state and pending_target; a redirect presented during the stall is not captured.
REQ-021 SHALL drive instr_address and link_addr combinationally from the pc register (zero-cycle latency from the register).
REQ-022 SHALL treat the first redirect only (REQ-013) as taking effect one instruction later, i.e. exactly one delay slot executes.

Reset
REQ-023 SHALL, on reset=1 at a rising clk edge, set pc=RESET_VECTOR, state=RUN, pending_target=0 and active=1, overriding clk_enable.
REQ-024 SHALL, on reset asserted while in DELAY, discard the pending target so that the first post-reset fetch is RESET_VECTOR.
REQ-025 SHALL drive all outputs to their reset values in the cycle immediately following the reset edge.

Structure
REQ-026 SHALL place the pc_sel encoding enum, the state enum and the RESET_VECTOR default in the shared CPU package used by the decoder.
REQ-027 SHALL contain one combinational sub-module, pc_target_calc, computing the branch, jump and register targets from pc, pc_sel, instr_readdata and reg_readdata.
REQ-028 SHALL contain no memory interface; the instruction fetch port is driven solely by instr_address.

Verification
REQ-029 SHALL cover: reset, then three cycles with pc_sel=00 -> instr_address = BFC00000, BFC00004, BFC00008, BFC0000C; link_addr = BFC00008 in the first cycle.
REQ-030 SHALL cover: a branch at BFC00010 with imm=16'hFFFC, pc_sel=01 -> delay slot at BFC00014, then BFC00004.
REQ-031 SHALL cover: J at BFC00020 with index 26'h0000040 -> delay slot at BFC00024, then B0000100.
REQ-032 SHALL cover: JR with reg_readdata=0 -> delay slot executes, pc=0, active drops to 0 the following cycle and stays 0 for 10 cycles with random pc_sel.
REQ-033 SHALL cover: clk_enable=0 for 3 cycles in DELAY -> pc and pending target held; after re-enable the redirect completes normally; a redirect in the delay slot is ignored.
REQ-034 SHALL cover: reset asserted during DELAY with clk_enable=0 -> next instr_address = BFC00000, active=1, no redirect afterwards.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: redirect-select encoding, sequencer states and reset vector.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DELAY  = 2'b01,
    ST_HALTED = 2'b10
  } seq_state_e;

  // Branch immediates count words, so scale to bytes after sign extension.
  function automatic logic [31:0] branch_byte_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation for branch, jump and register redirects.
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [25:0] instr_index_i,
  input  logic [31:0] reg_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] target_o
);

  logic [31:0] pc4;

  assign pc4        = pc_i + 32'd4;
  assign pc_plus4_o = pc4;

  always_comb begin
    target_o = pc4;
    case (pc_sel_e'(pc_sel_i))
      PC_BRANCH: target_o = pc4 + branch_byte_offset(instr_index_i[15:0]);
      PC_JUMP:   target_o = {pc4[31:28], instr_index_i, 2'b00};
      PC_REG:    target_o = reg_i;
      default:   target_o = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with one branch delay slot and halt-on-jump-to-zero.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] instr_readdata,
  input  logic [31:0] reg_readdata,
  output logic [31:0] instr_address,
  output logic [31:0] link_addr,
  output logic        active
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        active_q, active_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  // Opcode/register fields are decoded elsewhere; only the index field matters here.
  logic unused_opcode;
  assign unused_opcode = ^instr_readdata[31:26];

  pc_target_calc u_target (
    .pc_i          (pc_q),
    .pc_sel_i      (pc_sel),
    .instr_index_i (instr_readdata[25:0]),
    .reg_i         (reg_readdata),
    .pc_plus4_o    (pc_plus4),
    .target_o      (target)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    active_d = active_q;
    if (clk_enable) begin
      case (state_q)
        ST_RUN: begin
          pc_d = pc_plus4;
          if (pc_sel_e'(pc_sel) != PC_SEQ) begin
            pend_d  = target;
            state_d = ST_DELAY;
          end
        end
        // pc_sel is ignored here: a redirect sitting in the delay slot is dropped.
        ST_DELAY: begin
          pc_d = pend_q;
          if (pend_q == '0) begin
            state_d  = ST_HALTED;
            active_d = 1'b0;
          end else begin
            state_d  = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      pend_q   <= '0;
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      active_q <= active_d;
    end
  end

  assign instr_address = pc_q;
  assign link_addr     = pc_q + 32'd8;
  assign active        = active_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a queue-based fetch model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] instr_readdata = '0;
  logic [31:0] reg_readdata = '0;
  logic [31:0] instr_address;
  logic [31:0] link_addr;
  logic        active;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .pc_sel         (pc_sel),
    .instr_readdata (instr_readdata),
    .reg_readdata   (reg_readdata),
    .instr_address  (instr_address),
    .link_addr      (link_addr),
    .active         (active)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the current fetch address plus a queue of already-decided
  // future fetch addresses. A queued address is consumed by the next advance.
  logic [31:0] m_pc = '0;
  logic [31:0] fetch_q[$];
  bit          m_halted = 1'b0;
  bit          m_valid  = 1'b0;

  function automatic logic [31:0] redirect_target(input logic [31:0] pc, input logic [1:0] sel,
                                                  input logic [31:0] ins, input logic [31:0] rd);
    int          off_words;
    logic [31:0] nxt;
    nxt = pc + 32'd4;
    off_words = $signed(ins[15:0]);
    case (sel)
      2'b01:   return nxt + 32'(off_words * 4);
      2'b10:   return (nxt & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
      default: return rd;
    endcase
  endfunction

  always begin
    @(posedge clk);
    if (reset) begin
      m_pc = RV;
      fetch_q.delete();
      m_halted = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid && !m_halted && clk_enable) begin
      if (fetch_q.size() > 0) begin
        m_pc = fetch_q.pop_front();
        if (m_pc == 32'h0) m_halted = 1'b1;
      end else begin
        if (pc_sel != 2'b00)
          fetch_q.push_back(redirect_target(m_pc, pc_sel, instr_readdata, reg_readdata));
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    if (m_valid) begin
      chk("model instr_address", instr_address, m_pc);
      chk("model link_addr", link_addr, m_pc + 32'd8);
      chk("model active", {31'b0, active}, {31'b0, !m_halted});
    end
  end

  task automatic cyc(input bit rst, input bit ce, input logic [1:0] s,
                     input logic [31:0] ins, input logic [31:0] rd);
    reset          = rst;
    clk_enable     = ce;
    pc_sel         = s;
    instr_readdata = ins;
    reg_readdata   = rd;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_state(input string nm, input logic [31:0] pc, input bit act);
    chk({nm, " pc"}, instr_address, pc);
    chk({nm, " active"}, {31'b0, active}, {31'b0, act});
  endtask

  initial begin
    // Reset and sequential fetch
    cyc(1, 0, 2'b00, '0, '0);
    expect_state("reset", RV, 1'b1);
    chk("reset link_addr", link_addr, 32'hBFC0_0008);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("seq1", 32'hBFC0_0004, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("seq2", 32'hBFC0_0008, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("seq3", 32'hBFC0_000C, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("seq4", 32'hBFC0_0010, 1'b1);

    // Backward branch at BFC00010
    cyc(0, 1, 2'b01, 32'h0000_FFFC, '0);
    expect_state("branch slot", 32'hBFC0_0014, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("branch tgt", 32'hBFC0_0004, 1'b1);

    for (int unsigned i = 0; i < 7; i++) cyc(0, 1, 2'b00, '0, '0);
    expect_state("walk to 20", 32'hBFC0_0020, 1'b1);

    // Jump at BFC00020
    cyc(0, 1, 2'b10, 32'h0000_0040, '0);
    expect_state("jump slot", 32'hBFC0_0024, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("jump tgt", 32'hB000_0100, 1'b1);

    // Forward branch, stalled in the delay slot, redirect in slot ignored
    cyc(0, 1, 2'b01, 32'h0000_0010, '0);
    expect_state("stall slot", 32'hB000_0104, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(0, 0, 2'($urandom_range(1, 3)), $urandom, $urandom);
      expect_state("stall hold", 32'hB000_0104, 1'b1);
    end
    cyc(0, 1, 2'b11, '0, 32'h1234_5678);
    expect_state("stall tgt", 32'hB000_0144, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("after slot redirect", 32'hB000_0148, 1'b1);

    // Reset while in DELAY with the stall asserted
    cyc(0, 1, 2'b11, '0, 32'h1234_5678);
    expect_state("jr slot", 32'hB000_014C, 1'b1);
    cyc(1, 0, 2'b00, '0, '0);
    expect_state("reset in delay", RV, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("no stale redirect", 32'hBFC0_0004, 1'b1);

    // JR to zero halts
    cyc(0, 1, 2'b11, '0, 32'h0);
    expect_state("jr0 slot", 32'hBFC0_0008, 1'b1);
    cyc(0, 1, 2'b00, '0, '0);
    expect_state("halted", 32'h0, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      expect_state("halt hold", 32'h0, 1'b0);
    end

    // Randomized traffic, checked by the model every cycle
    cyc(1, 1, 2'b00, '0, '0);
    for (int unsigned i = 0; i < 600; i++) begin
      bit          r;
      bit          ce;
      logic [1:0]  s;
      logic [31:0] rd;
      r  = ($urandom_range(0, 59) == 0);
      ce = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      cyc(r, ce, s, $urandom, rd);
    end

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
